prefetch_issue_queue: RTL and testbench

PREFETCH_ISSUE_QUEUE -- requirements
Module: prefetch_issue_queue

---
 rtl/prefetch_pkg.sv | 15 +
 rtl/pf_addr_history.sv | 52 +++++
 rtl/prefetch_issue_queue.sv | 112 +++++++++++
 tb/tb_prefetch_issue_queue.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared constants, address type and saturating-counter helper for the prefetch issue queue.
package prefetch_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned CntWidth  = 16;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [CntWidth-1:0]  cnt_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (&v) ? v : v + CntWidth'(1);
  endfunction

endpackage

// File: rtl/pf_addr_history.sv
// Shift register of the most recently issued prefetch addresses with a parallel lookup.
module pf_addr_history
  import prefetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidth,
  parameter int unsigned HIST       = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  insert_valid,
  input  logic [ADDR_WIDTH-1:0] insert_addr,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  hit
);

  logic [ADDR_WIDTH-1:0] hist_q [HIST];
  logic [HIST-1:0]       valid_q;

  // Valid bits shift with the data; entry 0 is the newest.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      valid_q <= '0;
    end else if (insert_valid) begin
      valid_q[0] <= 1'b1;
      for (int unsigned i = 1; i < HIST; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Address storage; contents are meaningless where the valid bit is clear.
  always_ff @(posedge clock) begin
    if (insert_valid) begin
      hist_q[0] <= insert_addr;
      for (int unsigned i = 1; i < HIST; i++) begin
        hist_q[i] <= hist_q[i-1];
      end
    end
  end

  // Match the lookup address against every valid entry.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < HIST; i++) begin
      if (valid_q[i] && (hist_q[i] == lookup_addr)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prefetch_issue_queue.sv
// FIFO between the prefetcher and memory: filters duplicates against queued and recently
// issued addresses, drops on full, and issues head-first with a valid/ready handshake.
module prefetch_issue_queue
  import prefetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidth,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned HIST       = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pf_valid_i,
  input  logic [ADDR_WIDTH-1:0] pf_address_i,
  input  logic                  flush_i,
  output logic                  mem_valid_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  input  logic                  mem_ready_i,
  output logic                  overflow_o,
  output logic [CntWidth-1:0]   drop_cnt_o,
  output logic [CntWidth-1:0]   dup_cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_WIDTH-1:0] queue_q [DEPTH];
  logic [PtrW-1:0]       rd_q, wr_q;
  logic [CntW-1:0]       count_q;
  logic                  overflow_q;
  cnt_t                  drop_q, dup_q;

  logic            empty, full, pop, push, dup, drop_full, q_hit, h_hit;
  logic [PtrW-1:0] off;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));

  // A pop during flush is suppressed so the issued address never reaches history.
  assign pop = !empty && mem_ready_i && !flush_i;

  // Compare the incoming address against occupied queue slots; the popping head is included.
  always_comb begin
    q_hit = 1'b0;
    off   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PtrW'(i) - rd_q;
      if (({1'b0, off} < count_q) && (queue_q[i] == pf_address_i)) begin
        q_hit = 1'b1;
      end
    end
  end

  pf_addr_history #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .HIST       (HIST)
  ) u_history (
    .clock        (clock),
    .reset        (reset),
    .clear        (flush_i),
    .insert_valid (pop),
    .insert_addr  (queue_q[rd_q]),
    .lookup_addr  (pf_address_i),
    .hit          (h_hit)
  );

  // Duplicate wins over full; a simultaneous pop frees the slot for a full queue.
  assign dup       = pf_valid_i && !flush_i && (q_hit || h_hit);
  assign push      = pf_valid_i && !flush_i && !(q_hit || h_hit) && (!full || pop);
  assign drop_full = pf_valid_i && !flush_i && !(q_hit || h_hit) && full && !pop;

  // Pointer and occupancy update.
  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PtrW'(1);
      if (pop)  rd_q <= rd_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  // Queue storage write.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      queue_q[wr_q] <= pf_address_i;
    end
  end

  // Drop statistics; flush clears the sticky flag but keeps the counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
      dup_q      <= '0;
    end else begin
      if (dup)       dup_q  <= sat_inc(dup_q);
      if (drop_full) drop_q <= sat_inc(drop_q);
      if (flush_i)        overflow_q <= 1'b0;
      else if (drop_full) overflow_q <= 1'b1;
    end
  end

  assign mem_valid_o   = !empty;
  assign mem_address_o = empty ? '0 : queue_q[rd_q];
  assign overflow_o    = overflow_q;
  assign drop_cnt_o    = drop_q;
  assign dup_cnt_o     = dup_q;

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Scoreboard bench for prefetch_issue_queue: accepted addresses are queued as expected issues
// and compared when the DUT completes a handshake.
module tb_prefetch_issue_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        pf_valid_i;
  logic [31:0] pf_address_i;
  logic        flush_i;
  logic        mem_valid_o;
  logic [31:0] mem_address_o;
  logic        mem_ready_i;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;
  logic [15:0] dup_cnt_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] sb [$];

  prefetch_issue_queue #(
    .ADDR_WIDTH (32),
    .DEPTH      (8),
    .HIST       (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pf_valid_i    (pf_valid_i),
    .pf_address_i  (pf_address_i),
    .flush_i       (flush_i),
    .mem_valid_o   (mem_valid_o),
    .mem_address_o (mem_address_o),
    .mem_ready_i   (mem_ready_i),
    .overflow_o    (overflow_o),
    .drop_cnt_o    (drop_cnt_o),
    .dup_cnt_o     (dup_cnt_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One cycle of stimulus; accepted addresses go into the scoreboard.
  task automatic push(input logic [31:0] a, input bit accept);
    pf_valid_i   = 1'b1;
    pf_address_i = a;
    if (accept) sb.push_back(a);
    step();
    pf_valid_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || mem_valid_o) && n < budget) begin
      step();
      n++;
    end
    check("drain_sb_empty", sb.size(), 0);
    check("drain_valid_low", {31'b0, mem_valid_o}, 0);
  endtask

  // Handshake monitor: sampled mid-cycle, the values seen here are the ones the next edge uses.
  always @(negedge clock) begin
    if (!reset && !flush_i && mem_valid_o && mem_ready_i) begin
      if (sb.size() == 0) begin
        check("spurious_issue", sb.size(), 1);
      end else begin
        check("issue_order", mem_address_o, sb.pop_front());
      end
    end
  end

  initial begin
    reset        = 1'b1;
    pf_valid_i   = 1'b0;
    pf_address_i = '0;
    flush_i      = 1'b0;
    mem_ready_i  = 1'b1;
    step();
    step();
    check("rst_valid", {31'b0, mem_valid_o}, 0);
    check("rst_addr", mem_address_o, 0);
    check("rst_overflow", {31'b0, overflow_o}, 0);
    check("rst_drop", {16'b0, drop_cnt_o}, 0);
    check("rst_dup", {16'b0, dup_cnt_o}, 0);
    reset = 1'b0;
    step();

    // In-order issue with one-cycle latency.
    push(32'h0F, 1'b1);
    check("lat_valid", {31'b0, mem_valid_o}, 1);
    check("lat_addr", mem_address_o, 32'h0F);
    push(32'h11, 1'b1);
    push(32'h0C, 1'b1);
    push(32'h14, 1'b1);
    drain(10);
    check("t1_drop", {16'b0, drop_cnt_o}, 0);
    check("t1_dup", {16'b0, dup_cnt_o}, 0);

    // Fill beyond capacity with memory stalled.
    mem_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) push(32'(i), i < 8);
    check("full_drop", {16'b0, drop_cnt_o}, 2);
    check("full_overflow", {31'b0, overflow_o}, 1);
    check("full_head", mem_address_o, 32'h00);
    mem_ready_i = 1'b1;
    drain(20);

    // Duplicate against history, then aged out after four more issues.
    push(32'h10, 1'b1);
    drain(5);
    push(32'h10, 1'b0);
    check("hist_dup", {16'b0, dup_cnt_o}, 1);
    for (int i = 0; i < 4; i++) push(32'h30 + 32'(i), 1'b1);
    drain(10);
    push(32'h10, 1'b1);
    drain(5);
    check("hist_aged_dup", {16'b0, dup_cnt_o}, 1);

    // Full queue with simultaneous pop accepts; push matching the popping head is a duplicate.
    mem_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h40 + 32'(i), 1'b1);
    mem_ready_i = 1'b1;
    push(32'h20, 1'b1);
    check("fullpop_drop", {16'b0, drop_cnt_o}, 2);
    check("head_pre", mem_address_o, 32'h41);
    push(32'h41, 1'b0);
    check("head_dup", {16'b0, dup_cnt_o}, 2);
    drain(20);
    check("t4_drop", {16'b0, drop_cnt_o}, 2);

    // Stall stability, then flush.
    mem_ready_i = 1'b0;
    push(32'h13, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("hold_addr", mem_address_o, 32'h13);
      step();
    end
    check("pre_flush_overflow", {31'b0, overflow_o}, 1);
    flush_i = 1'b1;
    sb.delete();
    step();
    flush_i = 1'b0;
    check("flush_valid", {31'b0, mem_valid_o}, 0);
    check("flush_overflow", {31'b0, overflow_o}, 0);
    check("flush_drop_kept", {16'b0, drop_cnt_o}, 2);
    check("flush_dup_kept", {16'b0, dup_cnt_o}, 2);

    // Reset with entries in flight.
    push(32'h50, 1'b0);
    push(32'h51, 1'b0);
    push(32'h52, 1'b0);
    check("pre_rst_valid", {31'b0, mem_valid_o}, 1);
    reset = 1'b1;
    step();
    check("mid_rst_valid", {31'b0, mem_valid_o}, 0);
    check("mid_rst_addr", mem_address_o, 0);
    check("mid_rst_overflow", {31'b0, overflow_o}, 0);
    check("mid_rst_drop", {16'b0, drop_cnt_o}, 0);
    check("mid_rst_dup", {16'b0, dup_cnt_o}, 0);
    reset = 1'b0;
    mem_ready_i = 1'b1;
    push(32'h01, 1'b1);
    check("post_rst_addr", mem_address_o, 32'h01);
    drain(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
